// File: rtl/spi_window_assembler.sv
// Oversampled SPI column receiver assembling a KERNEL x KERNEL sliding window with image coordinates.
// Window is valid 1 cycle after word done; stalls hold the window, and a new word during a stall overwrites it and flags overrun.
module spi_window_assembler #(
  parameter int PIXEL_BITS  = 4,
  parameter int KERNEL      = 3,
  parameter int MSG_BITS    = 16,
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int SYNC_STAGES = 2,
  parameter int PRIME       = 1
) (
  input  logic                                   mainClk,
  input  logic                                   reset,
  input  logic                                   spiClk,
  input  logic                                   sdi,
  input  logic                                   ncs,
  output logic [KERNEL*KERNEL*PIXEL_BITS-1:0]    window,
  output logic                                   windowValid,
  input  logic                                   windowReady,
  output logic [$clog2(IMG_WIDTH)-1:0]           windowX,
  output logic [$clog2(IMG_HEIGHT)-1:0]          windowY,
  input  logic                                   errClear,
  output logic [1:0]                             errFlags
);

  localparam int COL_BITS = KERNEL * PIXEL_BITS;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int BW = $clog2(MSG_BITS + 1);
  localparam int CW = $clog2(KERNEL + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(MSG_BITS - 1);
  localparam logic [BW-1:0] BIT_FULL = BW'(MSG_BITS);
  localparam logic [CW-1:0] COL_FULL = CW'(KERNEL);

  logic [SYNC_STAGES-1:0] sclkPipe, sdiPipe, ncsPipe;
  logic                   sclkPrev, ncsPrev;
  logic                   sclkSync, sdiSync, ncsSync;
  logic                   sclkRise, ncsFall, ncsRise;

  assign sclkSync = sclkPipe[SYNC_STAGES-1];
  assign sdiSync  = sdiPipe[SYNC_STAGES-1];
  assign ncsSync  = ncsPipe[SYNC_STAGES-1];
  assign sclkRise = sclkSync & ~sclkPrev;
  assign ncsFall  = ~ncsSync & ncsPrev;
  assign ncsRise  = ncsSync & ~ncsPrev;

  always_ff @(posedge mainClk) begin
    if (reset) begin
      sclkPipe <= '0;
      sdiPipe  <= '0;
      ncsPipe  <= '0;
      sclkPrev <= 1'b0;
      ncsPrev  <= 1'b0;
    end else begin
      sclkPipe <= {sclkPipe[SYNC_STAGES-2:0], spiClk};
      sdiPipe  <= {sdiPipe[SYNC_STAGES-2:0], sdi};
      ncsPipe  <= {ncsPipe[SYNC_STAGES-2:0], ncs};
      sclkPrev <= sclkSync;
      ncsPrev  <= ncsSync;
    end
  end

  // Only the low COL_BITS of the message survive an MSB-first shift, so older bits fall off the top.
  logic                active;
  logic [BW-1:0]       bitCnt;
  logic [COL_BITS-1:0] shiftReg;
  logic                wordDone;
  logic                partialWord;

  assign partialWord = ncsRise && active && (bitCnt != '0) && (bitCnt != BIT_FULL);

  always_ff @(posedge mainClk) begin
    if (reset) begin
      active   <= 1'b0;
      bitCnt   <= '0;
      shiftReg <= '0;
      wordDone <= 1'b0;
    end else begin
      wordDone <= 1'b0;
      if (ncsFall) begin
        active <= 1'b1;
        bitCnt <= '0;
      end else if (ncsRise) begin
        active <= 1'b0;
        bitCnt <= '0;
      end else if (active && sclkRise && (bitCnt != BIT_FULL)) begin
        shiftReg <= {shiftReg[COL_BITS-2:0], sdiSync};
        bitCnt   <= bitCnt + 1'b1;
        wordDone <= (bitCnt == BIT_LAST);
      end
    end
  end

  logic          hasCol;
  logic [CW-1:0] rowCols, rowColsNext;
  logic          xWrap, qualify, overrun, validNext;
  logic [1:0]    errNext;

  always_comb begin
    xWrap       = 1'b0;
    rowColsNext = rowCols;
    qualify     = 1'b0;
    overrun     = 1'b0;
    validNext   = 1'b0;
    errNext     = errFlags;

    xWrap = hasCol && (windowX == X_LAST);
    if (!hasCol || xWrap) begin
      rowColsNext = CW'(1);
    end else if (rowCols != COL_FULL) begin
      rowColsNext = rowCols + 1'b1;
    end
    qualify   = (PRIME == 0) || (rowColsNext == COL_FULL);
    overrun   = wordDone && windowValid && !windowReady;
    validNext = (wordDone && qualify) || (windowValid && !windowReady);
    // Error events are OR-ed after the clear so a same-cycle event keeps its flag.
    errNext = (errClear ? 2'b00 : errFlags) | {partialWord, overrun};
  end

  always_ff @(posedge mainClk) begin
    if (reset) begin
      window      <= '0;
      windowValid <= 1'b0;
      windowX     <= '0;
      windowY     <= '0;
      errFlags    <= '0;
      hasCol      <= 1'b0;
      rowCols     <= '0;
    end else begin
      windowValid <= validNext;
      errFlags    <= errNext;
      if (wordDone) begin
        hasCol  <= 1'b1;
        rowCols <= rowColsNext;
        if (hasCol) begin
          windowX <= xWrap ? '0 : windowX + 1'b1;
          if (xWrap) begin
            windowY <= (windowY == Y_LAST) ? '0 : windowY + 1'b1;
          end
        end
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) begin
            window[(r*KERNEL+c)*PIXEL_BITS +: PIXEL_BITS] <= window[(r*KERNEL+c+1)*PIXEL_BITS +: PIXEL_BITS];
          end
          window[(r*KERNEL+KERNEL-1)*PIXEL_BITS +: PIXEL_BITS] <= shiftReg[(KERNEL-r)*PIXEL_BITS-1 -: PIXEL_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_window_assembler.sv
// Randomized SPI word stream against a queue-based reference model; a monitor scores every window handshake.
module tb_spi_window_assembler;

  localparam int PB = 4;
  localparam int K  = 3;
  localparam int MB = 16;
  localparam int W  = 8;
  localparam int H  = 3;
  localparam int WB = K * K * PB;

  typedef struct packed {
    logic [WB-1:0] win;
    logic [2:0]    x;
    logic [1:0]    y;
  } exp_t;

  logic          mainClk = 1'b0;
  logic          reset = 1'b1;
  logic          spiClk = 1'b0;
  logic          sdi = 1'b0;
  logic          ncs = 1'b1;
  logic          windowReady = 1'b1;
  logic          errClear = 1'b0;
  logic [WB-1:0] window, window0;
  logic          windowValid, windowValid0;
  logic [2:0]    windowX, windowX0;
  logic [1:0]    windowY, windowY0;
  logic [1:0]    errFlags, errFlags0;

  spi_window_assembler #(.PIXEL_BITS(PB), .KERNEL(K), .MSG_BITS(MB), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                         .SYNC_STAGES(2), .PRIME(1)) dut (
    .mainClk(mainClk), .reset(reset), .spiClk(spiClk), .sdi(sdi), .ncs(ncs),
    .window(window), .windowValid(windowValid), .windowReady(windowReady),
    .windowX(windowX), .windowY(windowY), .errClear(errClear), .errFlags(errFlags));

  spi_window_assembler #(.PIXEL_BITS(PB), .KERNEL(K), .MSG_BITS(MB), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                         .SYNC_STAGES(2), .PRIME(0)) dutNoPrime (
    .mainClk(mainClk), .reset(reset), .spiClk(spiClk), .sdi(sdi), .ncs(ncs),
    .window(window0), .windowValid(windowValid0), .windowReady(1'b1),
    .windowX(windowX0), .windowY(windowY0), .errClear(1'b0), .errFlags(errFlags0));

  always #5 mainClk = ~mainClk;

  int          checks = 0;
  int          passes = 0;
  int          nWords = 0;
  int          p0Words = 0;
  int          p0Count = 0;
  logic [11:0] hist[$];
  exp_t        expQ[$];
  logic [1:0]  errExp = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mainClk);
    #1;
  endtask

  function automatic int modelX();
    return (nWords == 0) ? 0 : (nWords - 1) % W;
  endfunction

  function automatic int modelY();
    return (nWords == 0) ? 0 : ((nWords - 1) / W) % H;
  endfunction

  // Window built from the last K accepted words; columns not yet received read as zero.
  function automatic logic [WB-1:0] modelWindow();
    logic [WB-1:0] win;
    logic [11:0]   col;
    int            pad;
    win = '0;
    pad = K - hist.size();
    for (int c = 0; c < K; c++) begin
      col = (c < pad) ? 12'h000 : hist[c - pad];
      for (int r = 0; r < K; r++) begin
        win[(r*K + c)*PB +: PB] = PB'(col >> ((K - 1 - r) * PB));
      end
    end
    return win;
  endfunction

  task automatic acceptWord(input logic [11:0] w);
    exp_t e;
    nWords++;
    p0Words++;
    hist.push_back(w);
    if (hist.size() > K) void'(hist.pop_front());
    e.win = modelWindow();
    e.x   = 3'(modelX());
    e.y   = 2'(modelY());
    if (expQ.size() > 0 && !windowReady) begin
      errExp[0] = 1'b1;
      void'(expQ.pop_back());
      expQ.push_back(e);
    end else if (modelX() >= K - 1) begin
      expQ.push_back(e);
    end
  endtask

  task automatic spiWord(input logic [15:0] w, input int nbits);
    ncs = 1'b0;
    tick(3);
    for (int i = 0; i < nbits; i++) begin
      sdi = w[15 - i];
      tick(2);
      spiClk = 1'b1;
      if (i == MB - 1) acceptWord(w[11:0]);
      tick(2);
      spiClk = 1'b0;
    end
    tick(2);
    ncs = 1'b1;
    if (nbits > 0 && nbits < MB) errExp[1] = 1'b1;
    tick(8);
  endtask

  task automatic modelReset();
    nWords = 0;
    p0Words = 0;
    p0Count = 0;
    hist.delete();
    expQ.delete();
    errExp = 2'b00;
  endtask

  task automatic checkState(input string tag);
    check({tag, ".x"}, 64'(windowX), 64'(modelX()));
    check({tag, ".y"}, 64'(windowY), 64'(modelY()));
    check({tag, ".err"}, 64'(errFlags), 64'(errExp));
    check({tag, ".win"}, 64'(window), 64'(modelWindow()));
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 200 && expQ.size() != 0; t++) tick(1);
    check({tag, ".drain"}, 64'(expQ.size()), 64'(0));
  endtask

  always @(negedge mainClk) begin
    if (!reset && windowValid && windowReady) begin
      if (expQ.size() == 0) begin
        check("spuriousValid", 64'(windowValid), 64'(0));
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("hs.win", 64'(window), 64'(e.win));
        check("hs.x", 64'(windowX), 64'(e.x));
        check("hs.y", 64'(windowY), 64'(e.y));
      end
    end
    if (!reset && windowValid0) p0Count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    modelReset();
    tick(1);
    check("rst.win", 64'(window), 64'(0));
    check("rst.valid", 64'(windowValid), 64'(0));
    check("rst.x", 64'(windowX), 64'(0));
    check("rst.y", 64'(windowY), 64'(0));
    check("rst.err", 64'(errFlags), 64'(0));

    spiWord(16'h0ABC, MB);
    spiWord(16'h0123, MB);
    check("prime.noValid", 64'(windowValid), 64'(0));
    spiWord(16'h0456, MB);
    check("abc.row0", 64'(window[11:0]), 64'(12'h41A));
    check("abc.row1", 64'(window[23:12]), 64'(12'h52B));
    check("abc.row2", 64'(window[35:24]), 64'(12'h63C));
    checkState("abc");

    while (nWords < W * H + 1) begin
      w = 16'($urandom_range(0, 65535));
      spiWord(w, MB);
      checkState("stream");
      if (nWords == W) check("row.lastX", 64'(windowX), 64'(W - 1));
      if (nWords == W + 1) check("row.wrapY", 64'(windowY), 64'(1));
    end
    check("frame.wrapY", 64'(windowY), 64'(0));
    drain("stream");

    for (int i = 0; i < 2; i++) spiWord(16'($urandom_range(0, 65535)), MB);
    tick(1);
    windowReady = 1'b0;
    for (int i = 0; i < 2; i++) spiWord(16'($urandom_range(0, 65535)), MB);
    checkState("overrun");
    check("overrun.valid", 64'(windowValid), 64'(1));
    windowReady = 1'b1;
    drain("overrun");
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
    errExp = 2'b00;
    tick(1);
    check("errClear", 64'(errFlags), 64'(0));

    spiWord(16'($urandom_range(0, 65535)), 7);
    checkState("partial");
    spiWord(16'($urandom_range(0, 65535)), MB);
    checkState("afterPartial");
    drain("partial");
    check("noPrime.count", 64'(p0Count), 64'(p0Words));
    check("noPrime.win", 64'(window0), 64'(modelWindow()));

    ncs = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      sdi = 1'b1;
      tick(2);
      spiClk = 1'b1;
      tick(2);
      spiClk = 1'b0;
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      sdi = 1'b1;
      tick(2);
      spiClk = 1'b1;
      tick(2);
      spiClk = 1'b0;
    end
    tick(2);
    ncs = 1'b1;
    tick(8);
    check("midRst.err", 64'(errFlags), 64'(0));
    spiWord(16'($urandom_range(0, 65535)), MB);
    checkState("midRst");
    check("midRst.oldCols", 64'(window[7:0]), 64'(0));
    drain("midRst");
    check("noPrime.count2", 64'(p0Count), 64'(p0Words));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
